// File: rtl/ts_pkt_buffer_if.sv
// Byte-stream ingress and packet-burst egress signals of one TS buffer channel.
// master: upstream feeder plus mux arbiter side; slave: the packet buffer.
interface ts_pkt_buffer_if;
    logic       ts_in_valid;
    logic [7:0] ts_in_data;
    logic       ts_in_sop;
    logic       ts_valid;
    logic [7:0] ts_data;
    logic       ts_eop;
    logic       ts_rdy;
    logic       ts_ack;

    modport master (
        output ts_in_valid, ts_in_data, ts_in_sop, ts_ack,
        input  ts_valid, ts_data, ts_eop, ts_rdy
    );

    modport slave (
        input  ts_in_valid, ts_in_data, ts_in_sop, ts_ack,
        output ts_valid, ts_data, ts_eop, ts_rdy
    );
endinterface

// File: rtl/ts_pkt_buffer.sv
// Collects whole TS packets into a slot RAM and bursts one packet per arbiter grant.
// Optional macro TS_SYNC_CHECK_EN: only sop bytes equal to 8'h47 start packets.
module ts_pkt_buffer #(
    parameter int PKT_LEN = 188,
    parameter int SLOT_AW = 2,
    parameter int BYTE_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    ts_pkt_buffer_if.slave     bus,
    output logic [SLOT_AW:0]   pkt_cnt,
    output logic [15:0]        drop_cnt
);
    localparam logic [SLOT_AW:0]   SLOTS   = (SLOT_AW+1)'(2**SLOT_AW);
    localparam logic [BYTE_AW-1:0] WR_LAST = BYTE_AW'(PKT_LEN-1);
    localparam logic [BYTE_AW:0]   RD_END  = (BYTE_AW+1)'(PKT_LEN);
    localparam logic [BYTE_AW:0]   RD_LAST = (BYTE_AW+1)'(PKT_LEN-1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic       {R_IDLE, R_SEND}         rstate_t;

    wstate_t              wstate, wstate_n;
    rstate_t              rstate, rstate_n;
    logic [SLOT_AW-1:0]   wr_slot, rd_slot;
    logic [BYTE_AW-1:0]   byte_cnt, byte_cnt_n, wr_idx;
    logic [BYTE_AW:0]     rd_idx, rd_idx_n;
    logic                 wr_en, commit, drop, sync_ok, start;
    logic                 issue, issue_last, rel_pkt;
    logic                 p1_valid, p1_last;
    logic [7:0]           ram_q;
    logic [7:0]           mem [0:(1<<(SLOT_AW+BYTE_AW))-1];

`ifdef TS_SYNC_CHECK_EN
    assign sync_ok = (bus.ts_in_data == 8'h47);
`else
    assign sync_ok = 1'b1;
`endif
    assign start = bus.ts_in_valid & bus.ts_in_sop & sync_ok;

    // Write side: a non-qualifying sop inside W_FILL falls through as plain data.
    always_comb begin
        wstate_n   = wstate;
        byte_cnt_n = byte_cnt;
        wr_idx     = byte_cnt;
        wr_en      = 1'b0;
        commit     = 1'b0;
        drop       = 1'b0;
        case (wstate)
            W_IDLE, W_DROP: begin
                if (start) begin
                    if (pkt_cnt < SLOTS) begin
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        byte_cnt_n = BYTE_AW'(1);
                        wstate_n   = W_FILL;
                    end else begin
                        drop     = 1'b1;
                        wstate_n = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (start) begin
                    drop       = 1'b1;
                    wr_en      = 1'b1;
                    wr_idx     = '0;
                    byte_cnt_n = BYTE_AW'(1);
                end else if (bus.ts_in_valid) begin
                    wr_en = 1'b1;
                    if (byte_cnt == WR_LAST) begin
                        commit   = 1'b1;
                        wstate_n = W_IDLE;
                    end else begin
                        byte_cnt_n = byte_cnt + 1'b1;
                    end
                end
            end
            default: wstate_n = W_IDLE;
        endcase
    end

    // Read side: addresses issue for PKT_LEN cycles; the slot is freed when the
    // last byte leaves the output register, two stages after its address.
    always_comb begin
        rstate_n   = rstate;
        rd_idx_n   = rd_idx;
        issue      = 1'b0;
        issue_last = 1'b0;
        rel_pkt    = 1'b0;
        case (rstate)
            R_IDLE: begin
                if (bus.ts_ack && bus.ts_rdy) begin
                    rstate_n = R_SEND;
                    rd_idx_n = '0;
                end
            end
            R_SEND: begin
                if (rd_idx != RD_END) begin
                    issue      = 1'b1;
                    issue_last = (rd_idx == RD_LAST);
                    rd_idx_n   = rd_idx + 1'b1;
                end
                if (p1_last) begin
                    rel_pkt  = 1'b1;
                    rstate_n = R_IDLE;
                end
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_n;
            rstate <= rstate_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt    <= '0;
            wr_slot     <= '0;
            rd_slot     <= '0;
            rd_idx      <= '0;
            p1_valid    <= 1'b0;
            p1_last     <= 1'b0;
            pkt_cnt     <= '0;
            drop_cnt    <= '0;
            bus.ts_valid <= 1'b0;
            bus.ts_data  <= '0;
            bus.ts_eop   <= 1'b0;
            bus.ts_rdy   <= 1'b0;
        end else begin
            byte_cnt <= byte_cnt_n;
            rd_idx   <= rd_idx_n;
            p1_valid <= issue;
            p1_last  <= issue_last;
            if (commit)
                wr_slot <= wr_slot + 1'b1;
            if (rel_pkt)
                rd_slot <= rd_slot + 1'b1;
            case ({commit, rel_pkt})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
            if (drop && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
            bus.ts_valid <= p1_valid;
            bus.ts_eop   <= p1_last;
            if (p1_valid)
                bus.ts_data <= ram_q;
            // Uses the pre-release state so rdy trails eop by at least one clock.
            bus.ts_rdy <= (pkt_cnt != '0) && (rstate == R_IDLE) && !(bus.ts_ack && bus.ts_rdy);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[{wr_slot, wr_idx}] <= bus.ts_in_data;
        if (issue)
            ram_q <= mem[{rd_slot, rd_idx[BYTE_AW-1:0]}];
    end
endmodule

// File: tb/tb_ts_pkt_buffer.sv
// Scoreboard bench for ts_pkt_buffer: a packet-level queue model predicts stored
// packets, drops and output bursts; a monitor compares every output byte.
module tb_ts_pkt_buffer;
    localparam int PKT_LEN = 188;
    localparam int SLOTS   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pkt_cnt;
    logic [15:0] drop_cnt;

    ts_pkt_buffer_if bus ();

    ts_pkt_buffer #(.PKT_LEN(PKT_LEN), .SLOT_AW(2), .BYTE_AW(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    logic [8:0] exp_q[$];
    logic [7:0] stored_bytes[$];
    logic [7:0] cur[$];
    bit   in_pkt = 0, ack_en = 0;
    int   occ = 0, drops = 0, exp_first = 0, burst_pos = 0;
    logic [7:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model of the ingress rules, in terms of packets and occupancy.
    function automatic void model_byte(input logic [7:0] d, input logic sop);
        bit st;
        st = sop;
`ifdef TS_SYNC_CHECK_EN
        st = sop && (d == 8'h47);
`endif
        if (st) begin
            if (in_pkt) begin
                drops++;
                cur.delete();
                cur.push_back(d);
            end else if (occ < SLOTS) begin
                in_pkt = 1;
                cur.delete();
                cur.push_back(d);
            end else begin
                drops++;
            end
        end else if (in_pkt) begin
            cur.push_back(d);
            if (cur.size() == PKT_LEN) begin
                foreach (cur[i]) stored_bytes.push_back(cur[i]);
                occ++;
                in_pkt = 0;
            end
        end
    endfunction

    always @(posedge clk)
        if (!rst && bus.ts_in_valid) model_byte(bus.ts_in_data, bus.ts_in_sop);

    // Monitor: pops one expected {eop,data} per output byte.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            burst_pos = 0;
            last_data = '0;
        end else if (bus.ts_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got data %0h eop %0b, required no output", bus.ts_data, bus.ts_eop);
            end else begin
                e = exp_q.pop_front();
                if (burst_pos == 0) check("first_latency", cyc, exp_first);
                check("out_byte", {bus.ts_eop, bus.ts_data}, e);
                if (e[8]) begin
                    occ--;
                    burst_pos = 0;
                    check("rdy_low_at_eop", bus.ts_rdy, 0);
                end else begin
                    burst_pos++;
                end
            end
            last_data = bus.ts_data;
        end else begin
            if (burst_pos != 0) begin
                check("burst_gap", bus.ts_valid, 1);
                burst_pos = 0;
            end
            check("idle_outputs", {bus.ts_eop, bus.ts_data}, {1'b0, last_data});
        end
    end

    // Called at a negedge with ts_rdy=1; the grant is sampled at the next posedge.
    task automatic issue_ack(input int hold);
        bus.ts_ack = 1'b1;
        check("grant_has_packet", stored_bytes.size() >= PKT_LEN, 1);
        for (int i = 0; i < PKT_LEN; i++)
            if (stored_bytes.size() > 0)
                exp_q.push_back({i == PKT_LEN-1, stored_bytes.pop_front()});
        exp_first = cyc + 3;
        @(posedge clk);
        repeat (hold) @(posedge clk);
        #1 bus.ts_ack = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ack_en && !rst && bus.ts_rdy && $urandom_range(0, 2) == 0) issue_ack(0);
        end
    end

    task automatic send_pkt(input int len, input logic [7:0] sop_byte, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin
                    bus.ts_in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            bus.ts_in_valid = 1'b1;
            bus.ts_in_sop   = (i == 0);
            bus.ts_in_data  = (i == 0) ? sop_byte : 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.ts_in_valid = 1'b0;
        bus.ts_in_sop   = 1'b0;
    endtask

    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ts_in_valid = 1'b1;
            bus.ts_in_sop   = 1'b0;
            bus.ts_in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.ts_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        ack_en = 1;
        while (!(exp_q.size() == 0 && stored_bytes.size() == 0 && occ == 0) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", t < 4000, 1);
        ack_en = 0;
        repeat (3) @(negedge clk);
        check("pkt_cnt", pkt_cnt, occ);
        check("drop_cnt", drop_cnt, drops);
    endtask

    task automatic wait_rdy();
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.ts_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rdy_timeout", bus.ts_rdy, 1);
    endtask

    task automatic model_reset();
        exp_q.delete();
        stored_bytes.delete();
        cur.delete();
        in_pkt = 0;
        occ    = 0;
        drops  = 0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1;
        bus.ts_in_valid = 1'b0;
        bus.ts_in_sop   = 1'b0;
        bus.ts_in_data  = '0;
        bus.ts_ack      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.ts_valid, 0);
        check("rst_data", bus.ts_data, 0);
        check("rst_eop", bus.ts_eop, 0);
        check("rst_rdy", bus.ts_rdy, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single packet: rdy rises one clock after the commit edge; ack held during burst.
        send_pkt(PKT_LEN, 8'h47, 0);
        @(negedge clk);
        check("t1_rdy_at_commit", bus.ts_rdy, 0);
        check("t1_pkt_cnt", pkt_cnt, 1);
        @(negedge clk);
        check("t1_rdy_after_commit", bus.ts_rdy, 1);
        issue_ack(40);
        drain();

        // Five packets with no grants: fifth dropped, then four in order.
        d0 = drops;
        for (int p = 0; p < 5; p++) send_pkt(PKT_LEN, 8'h47, 0);
        repeat (2) @(negedge clk);
        check("t2_pkt_cnt_full", pkt_cnt, 4);
        check("t2_drop_cnt", drop_cnt, d0 + 1);
        drain();

        // Short packet restarted by a new sop.
        d0 = drops;
        send_pkt(100, 8'h47, 0);
        send_pkt(PKT_LEN, 8'h47, 0);
        repeat (2) @(negedge clk);
        check("t3_drop_cnt", drop_cnt, d0 + 1);
        check("t3_pkt_cnt", pkt_cnt, 1);
        drain();

        // Commit lands on the same edge as the release of a burst.
        send_pkt(PKT_LEN, 8'h47, 0);
        wait_rdy();
        issue_ack(0);
        @(posedge clk);
        #1;
        send_pkt(PKT_LEN, 8'h47, 0);
        @(negedge clk);
        check("t4_eop_coincident", bus.ts_eop, 1);
        check("t4_pkt_cnt", pkt_cnt, 1);
        drain();

        // Reset mid-burst.
        send_pkt(PKT_LEN, 8'h47, 0);
        wait_rdy();
        issue_ack(0);
        repeat (50) @(posedge clk);
        #3;
        check("t5_mid_burst", bus.ts_valid, 1);
        rst = 1'b1;
        model_reset();
        #1;
        check("t5_rst_valid", bus.ts_valid, 0);
        check("t5_rst_data", bus.ts_data, 0);
        check("t5_rst_eop", bus.ts_eop, 0);
        check("t5_rst_rdy", bus.ts_rdy, 0);
        check("t5_rst_pkt_cnt", pkt_cnt, 0);
        check("t5_rst_drop_cnt", drop_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_pkt(PKT_LEN, 8'h47, 1);
        drain();

        // Packet whose sop byte is not the sync value.
        d0 = drops;
        send_pkt(PKT_LEN, 8'h00, 0);
        repeat (2) @(negedge clk);
`ifdef TS_SYNC_CHECK_EN
        check("t6_pkt_cnt", pkt_cnt, 0);
`else
        check("t6_pkt_cnt", pkt_cnt, 1);
`endif
        check("t6_drop_cnt", drop_cnt, d0);
        drain();

        // Randomized traffic with concurrent random grants.
        @(posedge clk);
        #1;
        ack_en = 1;
        for (int p = 0; p < 10; p++) begin
            if ($urandom_range(0, 3) == 0)
                send_pkt($urandom_range(20, PKT_LEN-1), 8'h47, 1);
            send_pkt(PKT_LEN, 8'h47, 1);
            if ($urandom_range(0, 2) == 0) send_junk($urandom_range(1, 10));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
